// File: rtl/sdram_read_if.sv
// Bus bundle between the SDRAM read engine and its surroundings:
// SDRAM command/address/data, arbiter handshake, refresh request and
// read-FIFO write port. The master side is the read engine.
interface sdram_read_if;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  bank_addr;
    logic [15:0] rd_data;
    logic        rd_trig;
    logic        rd_en;
    logic        rd_req;
    logic        rd_end;
    logic        aref_req;
    logic        rfifo_wr_en;
    logic [15:0] rfifo_wr_data;

    modport master (
        output rd_cmd, rd_addr, bank_addr, rd_req, rd_end, rfifo_wr_en, rfifo_wr_data,
        input  rd_data, rd_trig, rd_en, aref_req
    );

    modport slave (
        input  rd_cmd, rd_addr, bank_addr, rd_req, rd_end, rfifo_wr_en, rfifo_wr_data,
        output rd_data, rd_trig, rd_en, aref_req
    );
endinterface

// File: rtl/sdram_read.sv
// SDRAM read engine: requests the bus from the arbiter, opens a row,
// issues burst-4 READs column by column and closes the row with a
// precharge-all at a 256-word job boundary, a row end, or a pending
// refresh. Returned DQ words are written to the read FIFO CAS_LAT+1
// cycles after each READ.
// Optional build macro SDRAM_READ_DQ_REG_EN: adds one register stage on
// rd_data, moving the FIFO write (and the bus release) one cycle later.
module sdram_read #(
    parameter int unsigned RROW_ADDR_END  = 937,
    parameter int unsigned RCOL_MADDR_END = 256,
    parameter int unsigned CAS_LAT        = 3
) (
    input  logic         sclk,
    input  logic         rst_n,
    sdram_read_if.master bus
);
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_REQ  = 5'b00010;
    localparam logic [4:0] S_ACT  = 5'b00100;
    localparam logic [4:0] S_RD   = 5'b01000;
    localparam logic [4:0] S_PRE  = 5'b10000;

`ifdef SDRAM_READ_DQ_REG_EN
    localparam int unsigned RET_LAT = CAS_LAT + 2;
`else
    localparam int unsigned RET_LAT = CAS_LAT + 1;
`endif
    // READ history: bit k set means READ was on the bus k+1 cycles ago
    localparam int unsigned SR_W = RET_LAT + 2;

    localparam logic [11:0] ROW_LAST = 12'(RROW_ADDR_END);
    localparam logic [8:0]  COL_LAST = 9'(RCOL_MADDR_END - 4);

    logic [4:0]      state;
    logic [3:0]      rd_cmd_r;
    logic [11:0]     rd_addr_r;
    logic            rd_req_r;
    logic            rd_end_r;
    logic            wr_en_r;
    logic [15:0]     wr_data_r;
    logic [11:0]     row_addr;
    logic [8:0]      col_addr;
    logic [1:0]      burst_cnt;
    logic            act_done;
    logic            pre_done;
    logic            data_end_f;
    logic            row_end_f;
    logic            aref_f;
    logic [SR_W-1:0] rd_sr;
    logic [15:0]     dq_src;
    logic            read_on_bus;
    logic            ret_busy;
    logic            last_blk;
    logic            stop_rd;

    assign read_on_bus = (rd_cmd_r == CMD_READ);
    assign ret_busy    = read_on_bus | (|rd_sr) | wr_en_r;
    assign last_blk    = (row_addr == ROW_LAST) && (col_addr == COL_LAST);
    assign stop_rd     = data_end_f | row_end_f | bus.aref_req;

    assign bus.rd_cmd        = rd_cmd_r;
    assign bus.rd_addr       = rd_addr_r;
    assign bus.bank_addr     = 2'b00;
    assign bus.rd_req        = rd_req_r;
    assign bus.rd_end        = rd_end_r;
    assign bus.rfifo_wr_en   = wr_en_r;
    assign bus.rfifo_wr_data = wr_data_r;

    // Control FSM: arbitration, ACT/READ/PRE sequencing and address counters
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_cmd_r   <= CMD_NOP;
            rd_addr_r  <= '0;
            rd_req_r   <= 1'b0;
            rd_end_r   <= 1'b0;
            row_addr   <= '0;
            col_addr   <= '0;
            burst_cnt  <= '0;
            act_done   <= 1'b0;
            pre_done   <= 1'b0;
            data_end_f <= 1'b0;
            row_end_f  <= 1'b0;
            aref_f     <= 1'b0;
        end else begin
            rd_cmd_r <= CMD_NOP;
            rd_end_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.rd_trig) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // grant is only honoured once our request is visible
                    rd_req_r <= 1'b1;
                    if (rd_req_r && bus.rd_en) begin
                        rd_req_r <= 1'b0;
                        state    <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (!act_done) begin
                        rd_cmd_r  <= CMD_ACT;
                        rd_addr_r <= row_addr;
                        act_done  <= 1'b1;
                    end else begin
                        act_done <= 1'b0;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    burst_cnt <= burst_cnt + 2'd1;
                    if (burst_cnt == 2'd0) begin
                        rd_cmd_r  <= CMD_READ;
                        rd_addr_r <= {3'b000, col_addr};
                        if (last_blk) begin
                            row_addr   <= '0;
                            col_addr   <= '0;
                            data_end_f <= 1'b1;
                        end else if (col_addr == 9'd508) begin
                            col_addr   <= '0;
                            row_addr   <= row_addr + 12'd1;
                            row_end_f  <= 1'b1;
                            data_end_f <= 1'b1;
                        end else begin
                            col_addr <= col_addr + 9'd4;
                            if (col_addr == 9'd252) begin
                                data_end_f <= 1'b1;
                            end
                        end
                    end
                    if ((burst_cnt == 2'd3) && stop_rd) begin
                        aref_f <= bus.aref_req;
                        state  <= S_PRE;
                    end
                end
                S_PRE: begin
                    // bus is released only after the job's last FIFO write
                    if (!pre_done) begin
                        rd_cmd_r  <= CMD_PRE;
                        rd_addr_r <= 12'h400;
                        pre_done  <= 1'b1;
                    end else if (data_end_f || aref_f || bus.aref_req) begin
                        if (!ret_busy) begin
                            state      <= data_end_f ? S_IDLE : S_REQ;
                            rd_end_r   <= 1'b1;
                            pre_done   <= 1'b0;
                            data_end_f <= 1'b0;
                            row_end_f  <= 1'b0;
                            aref_f     <= 1'b0;
                        end
                    end else begin
                        state     <= S_ACT;
                        pre_done  <= 1'b0;
                        row_end_f <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SDRAM_READ_DQ_REG_EN
    logic [15:0] dq_q;

    // Extra input stage on the DQ bus
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            dq_q <= '0;
        end else begin
            dq_q <= bus.rd_data;
        end
    end

    assign dq_src = dq_q;
`else
    assign dq_src = bus.rd_data;
`endif

    // Return path: times the four FIFO writes of each READ, independent of FSM state
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sr     <= '0;
            wr_en_r   <= 1'b0;
            wr_data_r <= '0;
        end else begin
            rd_sr   <= {rd_sr[SR_W-2:0], read_on_bus};
            wr_en_r <= |rd_sr[RET_LAT+1 -: 4];
            if (|rd_sr[RET_LAT+1 -: 4]) begin
                wr_data_r <= dq_src;
            end
        end
    end
endmodule

// File: tb/tb_sdram_read.sv
// Self-checking bench for sdram_read. An SDRAM/arbiter model drives
// incrementing DQ words after each READ; a linear word-address model
// predicts READ columns, ACT rows, job boundaries and FIFO write timing.
`timescale 1ns/1ps
module tb_sdram_read;
    localparam int RROW = 2;
    localparam int RCOL = 128;
    localparam int CAS  = 3;
`ifdef SDRAM_READ_DQ_REG_EN
    localparam int LAT = CAS + 2;
`else
    localparam int LAT = CAS + 1;
`endif
    localparam int END_W = RROW * 512 + RCOL - 4;
    localparam int NCYC  = 4096;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] READ = 4'b0101;
    localparam logic [3:0] PRE  = 4'b0010;

    logic sclk  = 1'b0;
    logic rst_n = 1'b0;

    sdram_read_if bus();

    sdram_read #(
        .RROW_ADDR_END (RROW),
        .RCOL_MADDR_END(RCOL),
        .CAS_LAT       (CAS)
    ) dut (
        .sclk (sclk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model state
    int          maddr = 0;
    bit          exp_wr [NCYC];
    logic [15:0] exp_dat[NCYC];
    bit          dq_vld [NCYC];
    logic [15:0] dq_val [NCYC];
    int          dq_next = 0;
    int          last_wr_cyc = 0;
    bit          row_open = 0;
    bit          expect_pre = 0;
    int          last_read_col = -1;
    int          job_words = 0;
    int          rd_end_cnt = 0;
    bit          prev_rd_end = 0;
    bit          aref_arm = 0;
    int          aref_col = -1;
    bit          exp_reassert = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge sclk) cyc <= cyc + 1;

    // bus monitor, SDRAM DQ model and reference model
    always @(negedge sclk) begin
        int n;
        int col;
        bit stop;
        n = cyc % NCYC;
        if (rst_n) begin
            check("wr_en", 32'(bus.rfifo_wr_en), 32'(exp_wr[n]));
            if (exp_wr[n]) check("wr_data", 32'(bus.rfifo_wr_data), 32'(exp_dat[n]));
            if (bus.rfifo_wr_en) job_words++;
            exp_wr[n] = 0;
            check("bank", 32'(bus.bank_addr), 0);
            case (bus.rd_cmd)
                NOP: ;
                ACT: begin
                    check("act_twice", 32'(row_open), 0);
                    check("act_row", 32'(bus.rd_addr), 32'(maddr / 512));
                    row_open = 1;
                end
                READ: begin
                    col = maddr % 512;
                    check("read_open", 32'(row_open), 1);
                    check("read_after_stop", 32'(expect_pre), 0);
                    check("read_col", 32'(bus.rd_addr), 32'(col));
                    last_read_col = col;
                    for (int k = 0; k < 4; k++) begin
                        dq_vld[(cyc + CAS + k) % NCYC]  = 1;
                        dq_val[(cyc + CAS + k) % NCYC]  = 16'(dq_next);
                        exp_wr[(cyc + LAT + k) % NCYC]  = 1;
                        exp_dat[(cyc + LAT + k) % NCYC] = 16'(dq_next);
                        dq_next++;
                    end
                    last_wr_cyc = cyc + LAT + 3;
                    stop = 0;
                    if (maddr == END_W) begin
                        maddr = 0;
                        stop = 1;
                    end else begin
                        if (maddr % 256 == 252) stop = 1;
                        maddr += 4;
                    end
                    expect_pre = stop;
                    if (aref_arm && col == aref_col) begin
                        bus.aref_req = 1;
                        aref_arm = 0;
                        expect_pre = 1;
                        exp_reassert = !stop;
                    end
                end
                PRE: begin
                    check("pre_addr", 32'(bus.rd_addr), 32'h400);
                    row_open = 0;
                    expect_pre = 0;
                end
                default: check("cmd_legal", 32'(bus.rd_cmd), 32'(NOP));
            endcase
            if (bus.rd_end) begin
                check("rd_end_early", 32'(cyc >= last_wr_cyc), 1);
                check("rd_end_width", 32'(prev_rd_end), 0);
                rd_end_cnt++;
                bus.aref_req = 0;
            end
            prev_rd_end = bus.rd_end;
            bus.rd_data = dq_vld[n] ? dq_val[n] : 16'($urandom);
            dq_vld[n] = 0;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd"}, 32'(bus.rd_cmd), 32'(NOP));
        check({tag, "_addr"}, 32'(bus.rd_addr), 0);
        check({tag, "_req"}, 32'(bus.rd_req), 0);
        check({tag, "_end"}, 32'(bus.rd_end), 0);
        check({tag, "_wr_en"}, 32'(bus.rfifo_wr_en), 0);
        check({tag, "_wr_data"}, 32'(bus.rfifo_wr_data), 0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rd_req) begin
                ok = 1;
                break;
            end
            @(negedge sclk);
        end
    endtask

    task automatic wait_end(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sclk);
            if (bus.rd_end) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic grant(input int dly);
        repeat (dly) @(negedge sclk);
        bus.rd_en = 1;
        @(negedge sclk);
        check("req_clear", 32'(bus.rd_req), 0);
        bus.rd_en = 0;
    endtask

    // one read job: trigger, grant, re-grant after each refresh break, until bus released for good
    task automatic run_job(input int aref_c, input int gdelay, output int seg1_col);
        int start_w;
        int exp_words;
        int segs;
        bit ok;
        bit more;
        start_w = maddr;
        exp_words = (start_w / 256 + 1) * 256;
        if (start_w <= END_W && END_W + 4 < exp_words) exp_words = END_W + 4;
        exp_words -= start_w;
        job_words = 0;
        rd_end_cnt = 0;
        exp_reassert = 0;
        aref_col = aref_c;
        aref_arm = (aref_c >= 0);
        seg1_col = -1;
        segs = 0;
        more = 1;
        bus.rd_trig = 1;
        @(negedge sclk);
        bus.rd_trig = 0;
        while (more && segs < 6) begin
            wait_req(ok);
            check("req_seen", 32'(ok), 1);
            if (!ok) break;
            grant(gdelay);
            wait_end(ok);
            check("end_seen", 32'(ok), 1);
            if (!ok) break;
            segs++;
            if (segs == 1) seg1_col = last_read_col;
            @(negedge sclk);
            @(negedge sclk);
            if (exp_reassert) begin
                check("req_again", 32'(bus.rd_req), 1);
                exp_reassert = 0;
            end else begin
                check("req_idle", 32'(bus.rd_req), 0);
                more = 0;
            end
        end
        aref_arm = 0;
        repeat (4) @(negedge sclk);
        check("job_words", 32'(job_words), 32'(exp_words));
        check("rd_end_cnt", 32'(rd_end_cnt), 32'(segs));
        check("idle_req", 32'(bus.rd_req), 0);
        check("idle_cmd", 32'(bus.rd_cmd), 32'(NOP));
    endtask

    initial begin
        int s1;
        bit ok;
        bus.rd_trig  = 0;
        bus.rd_en    = 0;
        bus.aref_req = 0;
        bus.rd_data  = 0;
        repeat (3) @(negedge sclk);
        check_reset_vals("rst");
        rst_n = 1;
        @(negedge sclk);
        check_reset_vals("post_rst");

        // row 0, columns 0..252, first grant after 2 cycles
        run_job(-1, 2, s1);
        // row 0, columns 256..508, refresh raised at the data_end boundary
        run_job(508, $urandom_range(0, 3), s1);
        // row 1, refresh raised at column 64: resume at 68 in the same row
        run_job(64, $urandom_range(0, 3), s1);
        check("aref_stop_col", 32'(s1), 64);
        run_job(-1, $urandom_range(0, 3), s1);
        // last row ends early at RCOL-4 and wraps to row 0 column 0
        run_job(-1, $urandom_range(0, 3), s1);
        check("wrap_model", 32'(maddr), 0);
        for (int j = 0; j < 3; j++) begin
            run_job(4 * int'($urandom_range(0, 127)), $urandom_range(0, 3), s1);
        end

        // reset two cycles after a READ: in-flight words are dropped
        bus.rd_trig = 1;
        @(negedge sclk);
        bus.rd_trig = 0;
        wait_req(ok);
        check("rst_req_seen", 32'(ok), 1);
        grant(1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rd_cmd == READ) begin
                ok = 1;
                break;
            end
            @(negedge sclk);
        end
        check("rst_read_seen", 32'(ok), 1);
        repeat (2) @(negedge sclk);
        rst_n = 0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge sclk);
        @(negedge sclk);
        check_reset_vals("mid_rst_hold");
        for (int i = 0; i < NCYC; i++) begin
            exp_wr[i] = 0;
            dq_vld[i] = 0;
        end
        maddr = 0;
        row_open = 0;
        expect_pre = 0;
        last_wr_cyc = 0;
        aref_arm = 0;
        bus.aref_req = 0;
        rst_n = 1;
        job_words = 0;
        repeat (20) @(negedge sclk);
        check("post_rst_wr", 32'(job_words), 0);
        check("post_rst_cmd", 32'(bus.rd_cmd), 32'(NOP));
        run_job(-1, 1, s1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
